// File: rtl/div_radix2_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package div_radix2_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // Operand width the datapath is built for.
    localparam int DIV_WIDTH = 32;

    // Counter value of the final restoring step.
    localparam logic [4:0] DIV_LAST_STEP = 5'd31;

endpackage : div_radix2_pkg

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// One quotient bit per cycle on a 64-bit partial remainder. Signed operands
// are divided as magnitudes and sign-corrected on the final step. The stall
// holds IF/ID/EX while iterating. The result is presented together with a
// one-cycle ready pulse for the HILO write.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             stall_div,
    output logic             ready,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    div_state_e         state_r;
    div_state_e         state_next_s;

    logic [2*WIDTH-1:0] rem_r;
    logic [WIDTH-1:0]   div_r;
    logic [4:0]         cnt_r;
    logic               q_sign_r;
    logic               r_sign_r;

    logic [WIDTH:0]     top_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0]   q_fix_s;
    logic [WIDTH-1:0]   r_fix_s;
    logic               b_zero_s;

    // Two's-complement negation (wraps for the most negative value).
    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand; only negative signed operands are flipped.
    function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v,
                                               input logic             is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return neg_f(v);
        end else begin
            return v;
        end
    endfunction

    assign b_zero_s  = (b == {WIDTH{1'b0}});
    assign ready     = (state_r == DIV_DONE) & ~cancel;
    assign stall_div = ((state_r == DIV_IDLE) & start & ~cancel) | (state_r == DIV_BUSY);

    // One restoring step: the upper half shifted left keeps its carry-out in
    // bit WIDTH, so a 33-bit subtract decides the quotient bit without loss.
    always_comb begin
        top_s  = rem_r[2*WIDTH-1:WIDTH-1];
        diff_s = top_s - {1'b0, div_r};
        if (!diff_s[WIDTH]) begin
            rem_next_s = {diff_s[WIDTH-1:0], rem_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = {rem_r[2*WIDTH-2:0], 1'b0};
        end
        if (q_sign_r) begin
            q_fix_s = neg_f(rem_next_s[WIDTH-1:0]);
        end else begin
            q_fix_s = rem_next_s[WIDTH-1:0];
        end
        if (r_sign_r) begin
            r_fix_s = neg_f(rem_next_s[2*WIDTH-1:WIDTH]);
        end else begin
            r_fix_s = rem_next_s[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state logic; cancel always returns to idle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (cancel) begin
                    state_next_s = DIV_IDLE;
                end else if (start) begin
                    if (b_zero_s) begin
                        state_next_s = DIV_DONE;
                    end else begin
                        state_next_s = DIV_BUSY;
                    end
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (cancel) begin
                    state_next_s = DIV_IDLE;
                end else if (cnt_r == DIV_LAST_STEP) begin
                    state_next_s = DIV_DONE;
                end else begin
                    state_next_s = DIV_BUSY;
                end
            end
            DIV_DONE: begin
                state_next_s = DIV_IDLE;
            end
            default: begin
                state_next_s = DIV_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration and result registers; cancel freezes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r    <= {(2*WIDTH){1'b0}};
            div_r    <= {WIDTH{1'b0}};
            cnt_r    <= 5'd0;
            q_sign_r <= 1'b0;
            r_sign_r <= 1'b0;
            lo_o     <= {WIDTH{1'b0}};
            hi_o     <= {WIDTH{1'b0}};
        end else if (!cancel) begin
            case (state_r)
                DIV_IDLE: begin
                    if (start) begin
                        rem_r    <= {{WIDTH{1'b0}}, abs_f(a, signed_div)};
                        div_r    <= abs_f(b, signed_div);
                        cnt_r    <= 5'd0;
                        q_sign_r <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_sign_r <= signed_div & a[WIDTH-1];
                        if (b_zero_s) begin
                            lo_o <= {WIDTH{1'b1}};
                            hi_o <= a;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem_r <= rem_next_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == DIV_LAST_STEP) begin
                        lo_o <= q_fix_s;
                        hi_o <= r_fix_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : div_radix2
